regfile_wb_arbiter: RTL and testbench

Write-port controller for the 32 x 32-bit CPU register file. After reset it sequences a hardware clear of every register. It then shares the file's single write port (WE3/WA3/WD3) among N_REQ writeback requesters, such as ALU writeback and load writeback, using round-robin arbitration and a valid/ready handshake. It sits between the pipeline writeback sources and the register file write port; read ports are not touched.

---
 rtl/regfile_wb_arbiter_pkg.sv | 13 +
 rtl/regfile_wb_arbiter_rr.sv | 31 +++
 rtl/regfile_wb_arbiter.sv | 109 ++++++++++
 tb/tb_regfile_wb_arbiter.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants and state encoding for the register-file write-port controller.
package regfile_wb_arbiter_pkg;

    // Register-file geometry, shared with the register file itself.
    localparam int RF_ADDR_SIZE  = 5;
    localparam int RF_DATA_WIDTH = 32;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

endpackage

// File: rtl/regfile_wb_arbiter_rr.sv
// Combinational round-robin arbiter: grants the first requester at or above ptr.
module rr_arbiter #(
    parameter  int N_REQ = 2,
    localparam int GW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [GW-1:0]    ptr,
    output logic [N_REQ-1:0] grant,
    output logic [GW-1:0]    grant_id
);

    logic found;
    int   idx;

    // Walk the requesters starting at ptr, wrapping; first valid one wins.
    always_comb begin
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        idx      = 0;
        for (int o = 0; o < N_REQ; o++) begin
            idx = (int'(ptr) + o) % N_REQ;
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_id   = GW'(idx);
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port controller: clears every register after reset,
// then shares the single write port among N_REQ writeback sources.
//
//   state | meaning
//   CLEAR | writing zero to register cnt each cycle; no grants
//   RUN   | round-robin grant of the write port to requesters
module regfile_wb_arbiter #(
    parameter  int ADDR_SIZE  = regfile_wb_arbiter_pkg::RF_ADDR_SIZE,
    parameter  int DATA_WIDTH = regfile_wb_arbiter_pkg::RF_DATA_WIDTH,
    parameter  int N_REQ      = 2,
    localparam int GW         = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                        CLK,
    input  logic                        rst,
    input  logic [N_REQ-1:0]            req_valid,
    input  logic [N_REQ*ADDR_SIZE-1:0]  req_addr,
    input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
    output logic [N_REQ-1:0]            req_ready,
    output logic                        WE3,
    output logic [ADDR_SIZE-1:0]        WA3,
    output logic [DATA_WIDTH-1:0]       WD3,
    output logic                        busy,
    output logic [GW-1:0]               grant_id
);

    import regfile_wb_arbiter_pkg::*;

    state_t                  state, state_nxt;
    logic [ADDR_SIZE-1:0]    cnt, cnt_nxt;
    logic [GW-1:0]           ptr, ptr_nxt;
    logic [N_REQ-1:0]        arb_grant;
    logic [GW-1:0]           arb_id;
    logic                    xfer;
    logic [ADDR_SIZE-1:0]    sel_addr;
    logic [DATA_WIDTH-1:0]   sel_data;

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .req      (req_valid),
        .ptr      (ptr),
        .grant    (arb_grant),
        .grant_id (arb_id)
    );

    // Next-state, grant outputs and pointer advance.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        ptr_nxt   = ptr;
        req_ready = '0;
        grant_id  = '0;
        xfer      = 1'b0;
        sel_addr  = req_addr[int'(arb_id)*ADDR_SIZE +: ADDR_SIZE];
        sel_data  = req_data[int'(arb_id)*DATA_WIDTH +: DATA_WIDTH];
        case (state)
            CLEAR: begin
                cnt_nxt = cnt + 1'b1;
                if (cnt == '1) state_nxt = RUN;
            end
            RUN: begin
                req_ready = arb_grant;
                grant_id  = arb_id;
                xfer      = |arb_grant;
                if (xfer) ptr_nxt = (arb_id == GW'(N_REQ-1)) ? '0 : arb_id + 1'b1;
            end
            default: state_nxt = CLEAR;
        endcase
        // No handshake may complete on a reset edge.
        if (rst) begin
            req_ready = '0;
            grant_id  = '0;
            xfer      = 1'b0;
        end
    end

    // FSM, clear counter and round-robin pointer.
    always_ff @(posedge CLK) begin
        if (rst) begin
            state <= CLEAR;
            cnt   <= '0;
            ptr   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            ptr   <= ptr_nxt;
        end
    end

    // Registered write port; register 0 writes are swallowed by dropping WE3.
    always_ff @(posedge CLK) begin
        if (rst) begin
            WE3 <= 1'b0;
            WA3 <= '0;
            WD3 <= '0;
        end else if (state == CLEAR) begin
            WE3 <= 1'b1;
            WA3 <= cnt;
            WD3 <= '0;
        end else if (xfer) begin
            WE3 <= (sel_addr != '0);
            WA3 <= sel_addr;
            WD3 <= sel_data;
        end else begin
            WE3 <= 1'b0;
        end
    end

    assign busy = (state == CLEAR);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter with a write scoreboard and a
// register-file model fed by WE3/WA3/WD3.
module tb_regfile_wb_arbiter;

    logic        CLK;
    logic        rst;
    logic [1:0]  req_valid;
    logic [9:0]  req_addr;
    logic [63:0] req_data;
    logic [1:0]  req_ready;
    logic        WE3;
    logic [4:0]  WA3;
    logic [31:0] WD3;
    logic        busy;
    logic [0:0]  grant_id;

    logic [4:0]  a0, a1;
    logic [31:0] d0, d1;
    assign req_addr = {a1, a0};
    assign req_data = {d1, d0};

    logic [31:0] rf [32];

    typedef struct packed {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
    } wr_t;
    wr_t exp_q[$];

    int n_checks = 0;
    int n_err    = 0;

    regfile_wb_arbiter dut (
        .CLK       (CLK),
        .rst       (rst),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ready (req_ready),
        .WE3       (WE3),
        .WA3       (WA3),
        .WD3       (WD3),
        .busy      (busy),
        .grant_id  (grant_id)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) if (WE3) rf[WA3] <= WD3;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic push(input logic we, input logic [4:0] wa, input logic [31:0] wd);
        wr_t e;
        e.we = we; e.wa = wa; e.wd = wd;
        exp_q.push_back(e);
    endtask

    task automatic pop_check(input string tag);
        wr_t e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_err++;
            $error("FAIL %s scoreboard empty observed_we=%0b", tag, WE3);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_we"}, 64'(WE3), 64'(e.we));
            if (e.we) begin
                chk({tag, "_wa"}, 64'(WA3), 64'(e.wa));
                chk({tag, "_wd"}, 64'(WD3), 64'(e.wd));
            end
        end
    endtask

    task automatic reset_vals(input string tag);
        chk({tag, "_we"},    64'(WE3), 64'd0);
        chk({tag, "_wa"},    64'(WA3), 64'd0);
        chk({tag, "_wd"},    64'(WD3), 64'd0);
        chk({tag, "_busy"},  64'(busy), 64'd1);
        chk({tag, "_ready"}, 64'(req_ready), 64'd0);
        chk({tag, "_gid"},   64'(grant_id), 64'd0);
    endtask

    // Runs a full 32-cycle clear; optionally requires req_ready low throughout.
    task automatic clear_seq(input string tag, input bit chk_ready);
        for (int i = 0; i < 32; i++) push(1'b1, 5'(i), 32'd0);
        for (int i = 0; i < 32; i++) begin
            if (chk_ready) chk({tag, "_ready"}, 64'(req_ready), 64'd0);
            step();
            pop_check(tag);
            chk({tag, "_busy"}, 64'(busy), (i < 31) ? 64'd1 : 64'd0);
        end
    endtask

    initial begin
        rst = 1'b1; req_valid = 2'b00;
        a0 = '0; a1 = '0; d0 = '0; d1 = '0;

        // Reset, then clear sequence while idle
        step(); step();
        reset_vals("reset");
        rst = 1'b0;
        clear_seq("clear", 1'b1);
        step();
        chk("idle_we", 64'(WE3), 64'd0);
        chk("idle_wa_hold", 64'(WA3), 64'd31);
        chk("idle_wd_hold", 64'(WD3), 64'd0);

        // Single requester 0
        req_valid = 2'b01; a0 = 5'd5; d0 = 32'hDEADBEEF;
        #1;
        chk("single_ready", 64'(req_ready), 64'b01);
        chk("single_gid", 64'(grant_id), 64'd0);
        push(1'b1, 5'd5, 32'hDEADBEEF);
        step();
        req_valid = 2'b00;
        pop_check("single");
        step();
        chk("single_idle_we", 64'(WE3), 64'd0);
        chk("single_rf5", 64'(rf[5]), 64'hDEADBEEF);

        // Requester 1 alone, bringing ptr back to 0
        req_valid = 2'b10; a1 = 5'd9; d1 = 32'hCAFEF00D;
        #1;
        chk("r1_ready", 64'(req_ready), 64'b10);
        chk("r1_gid", 64'(grant_id), 64'd1);
        push(1'b1, 5'd9, 32'hCAFEF00D);
        step();
        req_valid = 2'b00;
        pop_check("r1");
        step();
        chk("r1_rf9", 64'(rf[9]), 64'hCAFEF00D);

        // Contention: both held valid, grants alternate
        req_valid = 2'b11; a0 = 5'd3; d0 = 32'hA0A0A0A0; a1 = 5'd7; d1 = 32'hB1B1B1B1;
        #1;
        for (int i = 0; i < 6; i++) begin
            chk("cont_ready", 64'(req_ready), (i % 2 == 0) ? 64'b01 : 64'b10);
            chk("cont_gid", 64'(grant_id), 64'(i % 2));
            if (i % 2 == 0) push(1'b1, 5'd3, 32'hA0A0A0A0);
            else            push(1'b1, 5'd7, 32'hB1B1B1B1);
            step();
            pop_check("cont");
        end
        req_valid = 2'b00;
        step();
        chk("cont_rf3", 64'(rf[3]), 64'hA0A0A0A0);
        chk("cont_rf7", 64'(rf[7]), 64'hB1B1B1B1);

        // Zero register: accepted, not written, ptr advances
        req_valid = 2'b01; a0 = 5'd0; d0 = 32'h1234;
        #1;
        chk("zero_ready", 64'(req_ready), 64'b01);
        push(1'b0, 5'd0, 32'h0);
        step();
        pop_check("zero");
        req_valid = 2'b11; a0 = 5'd10; d0 = 32'h11; a1 = 5'd11; d1 = 32'h22;
        #1;
        chk("zero_ptr_ready", 64'(req_ready), 64'b10);
        chk("zero_ptr_gid", 64'(grant_id), 64'd1);
        push(1'b1, 5'd11, 32'h22);
        step();
        req_valid = 2'b00;
        pop_check("zero_next");
        step();
        chk("zero_rf0", 64'(rf[0]), 64'd0);
        chk("zero_rf11", 64'(rf[11]), 64'h22);

        // Requests pending across reset release and the whole clear
        rst = 1'b1; req_valid = 2'b11;
        a0 = 5'd12; d0 = 32'h33; a1 = 5'd13; d1 = 32'h44;
        #1;
        chk("rst_ready", 64'(req_ready), 64'd0);
        step();
        reset_vals("rst2");
        rst = 1'b0;
        #1;
        clear_seq("clr2", 1'b1);
        chk("clr2_first_ready", 64'(req_ready), 64'b01);
        chk("clr2_first_gid", 64'(grant_id), 64'd0);
        push(1'b1, 5'd12, 32'h33);
        step();
        pop_check("clr2_g0");
        chk("clr2_second_ready", 64'(req_ready), 64'b10);
        push(1'b1, 5'd13, 32'h44);
        step();
        req_valid = 2'b00;
        pop_check("clr2_g1");
        step();
        chk("clr2_rf9_cleared", 64'(rf[9]), 64'd0);

        // Reset mid-operation after writing regs 1..4
        for (int i = 1; i <= 4; i++) begin
            req_valid = 2'b01; a0 = 5'(i); d0 = 32'h100 + 32'(i);
            #1;
            push(1'b1, 5'(i), 32'h100 + 32'(i));
            step();
            pop_check("pre_rst");
        end
        req_valid = 2'b00;
        step();
        for (int i = 1; i <= 4; i++) chk("pre_rst_rf", 64'(rf[i]), 64'h100 + 64'(i));
        req_valid = 2'b01; a0 = 5'd20; d0 = 32'h55; rst = 1'b1;
        #1;
        chk("midrst_ready", 64'(req_ready), 64'd0);
        step();
        reset_vals("midrst");
        rst = 1'b0; req_valid = 2'b00;
        #1;
        clear_seq("clr3", 1'b0);
        step();
        for (int i = 1; i <= 4; i++) chk("post_rst_rf", 64'(rf[i]), 64'd0);
        chk("post_rst_rf20", 64'(rf[20]), 64'd0);
        chk("post_rst_sb_empty", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
